led_shift_tx: RTL

- Downstream consumer of the LED pattern stage's enable/data_in pair.
- On each enable pulse, captures the 128-bit LED frame and shifts it serially to the external LED driver chain with a divided shift clock. It then issues a latch pulse and reports completion.
- Sits between the pattern/control logic and the board LED driver pins, in the led_phy hierarchy.

---
 rtl/led_pkg.sv | 15 +
 rtl/led_bit_timer.sv | 39 +++
 rtl/led_shift_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and default sizing for the LED serial transmit path.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } led_tx_state_t;

  localparam int LED_DATA_W  = 128;
  localparam int LED_CLK_DIV = 4;
  localparam int LED_LAT_W   = 2;

endpackage

// File: rtl/led_bit_timer.sv
// Interval timer: counts enabled cycles from zero and raises tc in the
// cycle where the count reaches lim-1, so an interval lasts exactly lim
// cycles. The count returns to zero on tc or on clr.
module led_bit_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] lim,
  output logic          tc
);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign tc = en && (cnt_reg == lim - CW'(1));

  // Next count: restart on clear or terminal count, otherwise advance.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr || tc) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/led_shift_tx.sv
// Serial LED frame transmitter: captures a frame on enable, shifts it out
// with a divided shift clock, pulses the latch strobe and reports done.
// Every output is a register loaded from the *_next value of the FSM.
module led_shift_tx
  import led_pkg::*;
#(
  parameter int DATA_W    = LED_DATA_W,
  parameter int CLK_DIV   = LED_CLK_DIV,
  parameter int LAT_W     = LED_LAT_W,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              drop,
  output logic              led_sclk,
  output logic              led_sdo,
  output logic              led_lat,
  output logic              led_oe_n
);

  localparam int BIT_W  = $clog2(DATA_W);
  localparam int DIV_CW = $clog2(CLK_DIV + 1);
  localparam int LAT_CW = $clog2(LAT_W + 1);
  // The latch interval reuses the divider, so it must fit both limits.
  localparam int CNT_W  = (DIV_CW > LAT_CW) ? DIV_CW : LAT_CW;

  localparam logic [CNT_W-1:0] DIV_LIM  = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] LAT_LIM  = CNT_W'(LAT_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  led_tx_state_t     state_reg, state_next;
  logic [DATA_W-1:0] shreg_reg, shreg_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              drop_reg, drop_next;
  logic              sclk_reg, sclk_next;
  logic              sdo_reg, sdo_next;
  logic              lat_reg, lat_next;
  logic              oe_n_reg, oe_n_next;

  logic              tmr_clr;
  logic              tmr_en;
  logic [CNT_W-1:0]  tmr_lim;
  logic              tmr_tc;

  // Bit that goes on the wire next.
  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  // Advance the frame by one bit toward the head end.
  function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  led_bit_timer #(
    .CW (CNT_W)
  ) u_div (
    .clk  (clk),
    .rstn (rstn),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .lim  (tmr_lim),
    .tc   (tmr_tc)
  );

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    drop_next    = 1'b0;
    sclk_next    = sclk_reg;
    sdo_next     = sdo_reg;
    lat_next     = lat_reg;
    oe_n_next    = oe_n_reg;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    tmr_lim      = DIV_LIM;

    case (state_reg)
      IDLE: begin
        // Hold the divider at zero so the first half-period is full length.
        tmr_clr   = 1'b1;
        sclk_next = 1'b0;
        lat_next  = 1'b0;
        if (enable) begin
          shreg_next   = data_in;
          bit_cnt_next = '0;
          busy_next    = 1'b1;
          sdo_next     = head_bit(data_in);
          state_next   = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        tmr_en    = 1'b1;
        drop_next = enable;
        if (tmr_tc) begin
          sclk_next  = 1'b1;
          state_next = SHIFT_HI;
        end
      end

      SHIFT_HI: begin
        tmr_en    = 1'b1;
        drop_next = enable;
        if (tmr_tc) begin
          sclk_next = 1'b0;
          if (bit_cnt_reg == LAST_BIT) begin
            lat_next   = 1'b1;
            sdo_next   = 1'b0;
            state_next = LATCH;
          end else begin
            shreg_next   = shift_one(shreg_reg);
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            sdo_next     = head_bit(shift_one(shreg_reg));
            state_next   = SHIFT_LO;
          end
        end
      end

      LATCH: begin
        tmr_en    = 1'b1;
        tmr_lim   = LAT_LIM;
        drop_next = enable;
        if (tmr_tc) begin
          lat_next   = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          // Drivers stay enabled once the first frame has been latched.
          oe_n_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      drop_reg    <= 1'b0;
      sclk_reg    <= 1'b0;
      sdo_reg     <= 1'b0;
      lat_reg     <= 1'b0;
      oe_n_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      bit_cnt_reg <= bit_cnt_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      drop_reg    <= drop_next;
      sclk_reg    <= sclk_next;
      sdo_reg     <= sdo_next;
      lat_reg     <= lat_next;
      oe_n_reg    <= oe_n_next;
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign drop     = drop_reg;
  assign led_sclk = sclk_reg;
  assign led_sdo  = sdo_reg;
  assign led_lat  = lat_reg;
  assign led_oe_n = oe_n_reg;

endmodule
